// File: rtl/usb_system_pio_pkg.sv
// Shared constants for the parametrised input PIO: register map, edge modes, helpers.
package usb_system_pio_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        PIO_ADDR_DATA = 2'd0,
        PIO_ADDR_RSVD = 2'd1,
        PIO_ADDR_MASK = 2'd2,
        PIO_ADDR_EDGE = 2'd3
    } pio_addr_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Counter must hold 0..DEBOUNCE_CYCLES; keep at least one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/usb_system_pio_debounce.sv
// One input bit: synchroniser chain followed by a stable-count debouncer.
module usb_system_pio_debounce
    import usb_system_pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic stable_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable_q <= 1'b0;
                end else begin
                    stable_q <= sync;
                end
            end
        end else begin : g_debounce
            localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_d;

            // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
            always_comb begin
                cnt_d    = '0;
                stable_d = stable_q;
                if (sync != stable_q) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        stable_d = sync;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end
        end
    endgenerate

    assign stable_o = stable_q;

endmodule

// File: rtl/usb_system_pio_in_irq.sv
// Avalon-MM input PIO: per-bit debounced inputs, sticky edge capture, maskable level irq.
module usb_system_pio_in_irq
    import usb_system_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_MODE       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    logic [WIDTH-1:0]  stable;
    logic [WIDTH-1:0]  stable_dly_q;
    logic [WIDTH-1:0]  mask_q,     mask_d;
    logic [WIDTH-1:0]  edge_cap_q, edge_cap_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              irq_q,      irq_d;
    logic [WIDTH-1:0]  rise, fall, edge_evt, edge_clr;
    logic              unused_ok;

    // Read strobe has no side effects and upper write bits are don't-care.
    assign unused_ok = ^{read, writedata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        usb_system_pio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .in_i     (in_port[i]),
            .stable_o (stable[i])
        );
    end

    always_comb begin
        rise       = stable & ~stable_dly_q;
        fall       = ~stable & stable_dly_q;
        edge_evt   = '0;
        edge_clr   = '0;
        mask_d     = mask_q;
        readdata_d = '0;

        if (EDGE_MODE == EDGE_RISE) begin
            edge_evt = rise;
        end else if (EDGE_MODE == EDGE_FALL) begin
            edge_evt = fall;
        end else begin
            edge_evt = rise | fall;
        end

        if (write && (address == PIO_ADDR_EDGE)) begin
            edge_clr = writedata[WIDTH-1:0];
        end
        if (write && (address == PIO_ADDR_MASK)) begin
            mask_d = writedata[WIDTH-1:0];
        end
        // A clear colliding with a new event leaves the bit set.
        edge_cap_d = (edge_cap_q & ~edge_clr) | edge_evt;

        irq_d = |(edge_cap_q & mask_q);

        case (pio_addr_e'(address))
            PIO_ADDR_DATA: readdata_d = DATA_W'(stable);
            PIO_ADDR_MASK: readdata_d = DATA_W'(mask_q);
            PIO_ADDR_EDGE: readdata_d = DATA_W'(edge_cap_q);
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_dly_q <= '0;
            mask_q       <= '0;
            edge_cap_q   <= '0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            stable_dly_q <= stable;
            mask_q       <= mask_d;
            edge_cap_q   <= edge_cap_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_usb_system_pio_in_irq.sv
// Four PIO configurations on a shared bus, checked cycle by cycle against a behavioural model.
module tb_usb_system_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd    [4];
    logic        irq_o [4];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // u0: rising, debounced; u1: falling; u2: any edge, 3 sync stages; u3: default 2-bit port
    usb_system_pio_in_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) u0 (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq_o[0]));
    usb_system_pio_in_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_MODE(1)) u1 (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq_o[1]));
    usb_system_pio_in_irq #(.WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2)) u2 (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq_o[2]));
    usb_system_pio_in_irq u3 (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .in_port(in_port[1:0]), .readdata(rd[3]), .irq(irq_o[3]));

    function automatic int w_of(input int k);  return (k == 3) ? 2 : 4; endfunction
    function automatic int s_of(input int k);  return (k == 2) ? 3 : 2; endfunction
    function automatic int dc_of(input int k); return (k == 0) ? 4 : 0; endfunction
    function automatic int em_of(input int k); return (k == 1) ? 1 : ((k == 2) ? 2 : 0); endfunction

    // Model state: input history (hist[n] = input sampled n+1 edges ago) and per-instance registers
    logic [3:0]  hist   [8];
    logic [3:0]  m_stab [4];
    logic [3:0]  m_prev [4];
    logic [3:0]  m_ec   [4];
    logic [3:0]  m_msk  [4];
    int          m_run  [4][4];
    logic [31:0] m_rd   [4];
    logic        m_irq  [4];

    task automatic model_edge();
        logic [3:0] m, sync, ev, clr;
        if (reset) begin
            for (int i = 0; i < 8; i++) hist[i] = 4'h0;
            for (int k = 0; k < 4; k++) begin
                m_stab[k] = 4'h0; m_prev[k] = 4'h0; m_ec[k] = 4'h0; m_msk[k] = 4'h0;
                m_rd[k] = 32'h0; m_irq[k] = 1'b0;
                for (int b = 0; b < 4; b++) m_run[k][b] = 0;
            end
            return;
        end
        for (int k = 0; k < 4; k++) begin
            m = (w_of(k) == 4) ? 4'hF : 4'h3;
            sync = hist[s_of(k) - 1] & m;
            case (address)
                2'd0:    m_rd[k] = {28'h0, m_stab[k]};
                2'd1:    m_rd[k] = 32'h0;
                2'd2:    m_rd[k] = {28'h0, m_msk[k]};
                default: m_rd[k] = {28'h0, m_ec[k]};
            endcase
            m_irq[k] = |(m_ec[k] & m_msk[k]);
            case (em_of(k))
                0:       ev = m_stab[k] & ~m_prev[k];
                1:       ev = ~m_stab[k] & m_prev[k];
                default: ev = m_stab[k] ^ m_prev[k];
            endcase
            clr = (write && address == 2'd3) ? (writedata[3:0] & m) : 4'h0;
            m_ec[k] = ((m_ec[k] & ~clr) | ev) & m;
            if (write && address == 2'd2) m_msk[k] = writedata[3:0] & m;
            m_prev[k] = m_stab[k];
            // m_run counts consecutive cycles the synchronised input has disagreed with stable
            for (int b = 0; b < w_of(k); b++) begin
                if (dc_of(k) == 0) begin
                    m_stab[k][b] = sync[b];
                end else if (sync[b] == m_stab[k][b]) begin
                    m_run[k][b] = 0;
                end else if (m_run[k][b] + 1 >= dc_of(k)) begin
                    m_stab[k][b] = sync[b];
                    m_run[k][b] = 0;
                end else begin
                    m_run[k][b] = m_run[k][b] + 1;
                end
            end
        end
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = in_port;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rd_u%0d", k), rd[k], m_rd[k]);
            check($sformatf("irq_u%0d", k), {31'h0, irq_o[k]}, {31'h0, m_irq[k]});
        end
    endtask

    task automatic bus_write(input logic [1:0] adr, input logic [31:0] wd);
        address = adr; writedata = wd; write = 1'b1;
        step();
        write = 1'b0;
    endtask

    initial begin
        int found;
        reset = 1'b1; address = 2'd0; read = 1'b1; write = 1'b0; writedata = 32'h0;
        in_port = 4'b0011;

        // Reset with inputs high, then release
        repeat (3) step();
        check("t1_data_in_reset", rd[3], 32'h0);
        reset = 1'b0;
        repeat (3) step();
        check("t1_data_early", rd[3], 32'h0);
        step();
        check("t1_data_latency", rd[3], 32'h3);
        address = 2'd3;
        step();
        check("t1_edge_cap", rd[3], 32'h3);

        // Debounce: 3-cycle glitch rejected, 4-cycle hold accepted
        in_port = 4'b0000;
        repeat (12) step();
        bus_write(2'd3, 32'hF);
        step();
        check("t2_cleared", rd[0], 32'h0);
        in_port = 4'b0001;
        repeat (3) step();
        in_port = 4'b0000;
        repeat (8) step();
        check("t2_glitch_edge", rd[0], 32'h0);
        address = 2'd0;
        step();
        check("t2_glitch_data", rd[0], 32'h0);
        in_port = 4'b0001;
        repeat (8) step();
        check("t2_hold_data", rd[0], 32'h1);
        address = 2'd3;
        step();
        check("t2_hold_edge", rd[0], 32'h1);

        // Masking: bit0 edge masked off, bit1 edge raises irq, clear drops it a cycle later
        bus_write(2'd2, 32'h2);
        bus_write(2'd3, 32'hF);
        in_port = 4'b0000;
        repeat (8) step();
        in_port = 4'b0001;
        repeat (10) step();
        check("t3_edge0", rd[0], 32'h1);
        check("t3_irq_masked", {31'h0, irq_o[0]}, 32'h0);
        in_port = 4'b0011;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rd[0][1]) begin found = 1; break; end
        end
        check("t3_edge1_seen", found, 1);
        check("t3_irq_set", {31'h0, irq_o[0]}, 32'h1);
        bus_write(2'd3, 32'h2);
        check("t3_irq_lag", {31'h0, irq_o[0]}, 32'h1);
        step();
        check("t3_irq_clear", {31'h0, irq_o[0]}, 32'h0);

        // Clear colliding with a fresh bit1 event: event wins
        in_port = 4'b0001;
        repeat (10) step();
        in_port = 4'b0011;
        repeat (10) step();
        check("t4_irq_pre", {31'h0, irq_o[0]}, 32'h1);
        in_port = 4'b0001;
        repeat (10) step();
        in_port = 4'b0011;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_stab[0][1] && !m_prev[0][1]) begin
                bus_write(2'd3, 32'h2);
                found = 1;
                break;
            end
            step();
        end
        check("t4_collision_hit", found, 1);
        step();
        check("t4_edge_kept", rd[0] & 32'h2, 32'h2);
        check("t4_irq_kept", {31'h0, irq_o[0]}, 32'h1);

        // Falling-only vs any-edge capture on bit2
        bus_write(2'd3, 32'hF);
        in_port = 4'b0111;
        repeat (10) step();
        check("t5_fall_ignores_rise", rd[1], 32'h0);
        check("t5_any_rise", rd[2], 32'h4);
        bus_write(2'd3, 32'hF);
        in_port = 4'b0011;
        repeat (10) step();
        check("t5_fall_capture", rd[1], 32'h4);
        check("t5_any_fall", rd[2], 32'h4);

        // Register map: mask width clipping, reserved reads, ignored data writes, read-before-write
        bus_write(2'd2, 32'hFFFF_FFFF);
        step();
        check("t6_mask_w2", rd[3], 32'h3);
        check("t6_mask_w4", rd[0], 32'hF);
        address = 2'd1;
        step();
        check("t6_rsvd_u3", rd[3], 32'h0);
        check("t6_rsvd_u0", rd[0], 32'h0);
        bus_write(2'd0, 32'hFFFF_FFFF);
        address = 2'd2;
        step();
        check("t6_data_wr_ignored", rd[3], 32'h3);
        address = 2'd0;
        step();
        check("t6_data_unchanged", rd[3], 32'h3);
        bus_write(2'd2, 32'h0);
        check("t6_read_pre_write", rd[0], 32'hF);
        step();
        check("t6_read_post_write", rd[0], 32'h0);

        // Randomised traffic with sparse input changes and occasional mid-run reset
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ (4'h1 << $urandom_range(0, 3));
            reset     = ($urandom_range(0, 149) == 0);
            address   = 2'($urandom_range(0, 3));
            write     = ($urandom_range(0, 3) == 0);
            read      = ($urandom_range(0, 1) == 0);
            writedata = $urandom;
            step();
        end
        reset = 1'b0;
        write = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
